sketch_update_ctrl: RTL and testbench
=====================================

# sketch_update_ctrl

Read-modify-write update engine sitting directly upstream of the two-port sketch counter RAM. It accepts a stream of (hashed address, increment) items and reads the counter on RAM port A. It adds the increment and writes the result back on RAM port B, sustaining one item per clock with same-address hazard forwarding. After reset or on request, it zero-fills the whole RAM before accepting traffic, and it reports every committed counter value downstream.

## Interface
Parameters:
- `DW`, 32, counter/data width; must match the RAM's DW.
- `HW`, 10, hash/address width; RAM depth is 2^HW.
- `IW`, 8, increment width; IW ≤ DW.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `clear_i`  in  1  one-cycle request to re-run the zero-fill.
- `in_valid_i`  in  1  update item valid.
- `in_ready_o`  out  1  ready to accept an update item.
- `in_addr_i`  in  HW  counter address (hash index).
- `in_inc_i`  in  IW  unsigned increment.
- `ram_wea_o`  out  1  port A write enable; constant 0 (port A is read-only here).
- `ram_addra_o`  out  HW  port A read address.
- `ram_dina_o`  out  DW  port A write data; constant 0.
- `ram_douta_i`  in  DW  port A read data, registered, valid 1 cycle after address.
- `ram_web_o`  out  1  port B write enable.
- `ram_addrb_o`  out  HW  port B write address.
- `ram_dinb_o`  out  DW  port B write data.
- `upd_valid_o`  out  1  committed-update strobe (no backpressure).
- `upd_addr_o`  out  HW  committed address.
- `upd_count_o`  out  DW  new counter value written.
- `init_done_o`  out  1  high while in RUN.

## Operation
The controller has two states, INIT and RUN.
- INIT:
  - An HW-bit sweep counter starts at 0 and issues one write per cycle on port B: `ram_web_o=1`, `ram_addrb_o`=counter, `ram_dinb_o`=0.
  - After address 2^HW−1 is written, the state moves to RUN; the sweep counter wraps to 0.
  - `in_ready_o=0` throughout INIT.
- RUN:
  - `in_ready_o = ~clear_i`.
  - Accept on `in_valid_i & in_ready_o`: `ram_addra_o=in_addr_i` combinationally, and the address and increment are registered into S1.
  - When accepting is not possible, `ram_addra_o` holds its last value; the read result is ignored.
- S1 (cycle after accept):
  - The base value is `ram_douta_i`, unless `s1_addr` equals the address written on port B in the previous cycle (forwarding register valid). In that case the base is the forwarded data.
  - sum = base + zero-extended `inc`.
  - Outputs in the same cycle: `ram_web_o=1`, `ram_addrb_o=s1_addr`, `ram_dinb_o=sum`.
  - The same values are presented on `upd_valid_o`/`upd_addr_o`/`upd_count_o` in that cycle.
  - The forwarding register captures (addr, sum) at the edge; its valid bit is the S1 valid bit.
- `clear_i` in RUN:
  - No item is accepted that cycle.
  - An S1 item present in that cycle still commits.
  - The next cycle enters INIT, the forwarding register is invalidated, and the sweep counter is 0.
  - `clear_i` during INIT is ignored.
- Port B is never driven by S1 and the sweep in the same cycle: the sweep starts only after S1 has drained.

## Timing
- Reset values:
  - State INIT, sweep counter 0, S1 and forwarding valid 0.
  - `in_ready_o=0`, `ram_web_o=0`, `upd_valid_o=0`, `init_done_o=0`.
  - All address and data outputs 0.
- Reset timing:
  - The first sweep write occurs in the first cycle after `rst` deasserts.
  - RUN begins 2^HW cycles later.
- Update latency:
  - An item accepted in cycle t is written at the edge ending cycle t+1; `upd_valid_o` is high in t+1.
  - Throughput is 1 item per cycle.
- Back-to-back same address: an item in t and t+1 to the same address gives old+i1 then old+i1+i2, with no stall.
- Non-adjacent repeats (t, t+2): these read the RAM directly. The write committed at end of t+1 is visible to a read issued in t+2.
- Reset asserted mid-operation: any in-flight S1 item is dropped without a write, and the zero-fill restarts.

## Configuration
- `SKETCH_SAT_EN` defined: the sum saturates at 2^DW−1; a counter at maximum stays at maximum.
- `SKETCH_SAT_EN` undefined: the sum wraps modulo 2^DW.

## Test plan
Defaults throughout: HW=10, DW=32, IW=8.
- Reset, then idle: `ram_web_o` is high for exactly 1024 cycles with addresses 0..1023 and data 0; `init_done_o` and `in_ready_o` rise the next cycle.
- Single item addr=5, inc=3 after init: `ram_web_o` high one cycle later with addrb=5, dinb=3; `upd_count_o=3`.
- Four consecutive items to addr=7 with inc 1, 2, 3, 4: `upd_count_o` reads 1, 3, 6, 10 on consecutive cycles; RAM[7]=10.
- Alternating addresses 9, 10, 9 with inc 1 each, one per cycle: committed values 1, 1, 2.
- Preload RAM[3]=0xFFFFFFFE via updates, then apply inc=5: with `SKETCH_SAT_EN` the result is 0xFFFFFFFF; without it, 0x00000003.
- Pulse `clear_i` while an S1 item (addr=2, inc=1) is in flight: the item commits 1, then a 1024-cycle sweep runs, and a read of RAM[2] afterwards returns 0.

Source files
------------

// File: rtl/sketch_update_ctrl_if.sv
// Update-stream, RAM-port and committed-update bundle for sketch_update_ctrl.
// master = producer/RAM side, slave = the controller.
interface sketch_update_ctrl_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned HW = 10,
   parameter int unsigned IW = 8
);
   logic          in_valid_i;
   logic          in_ready_o;
   logic [HW-1:0] in_addr_i;
   logic [IW-1:0] in_inc_i;
   logic          ram_wea_o;
   logic [HW-1:0] ram_addra_o;
   logic [DW-1:0] ram_dina_o;
   logic [DW-1:0] ram_douta_i;
   logic          ram_web_o;
   logic [HW-1:0] ram_addrb_o;
   logic [DW-1:0] ram_dinb_o;
   logic          upd_valid_o;
   logic [HW-1:0] upd_addr_o;
   logic [DW-1:0] upd_count_o;

   modport master (
      output in_valid_i, in_addr_i, in_inc_i, ram_douta_i,
      input  in_ready_o, ram_wea_o, ram_addra_o, ram_dina_o, ram_web_o, ram_addrb_o,
             ram_dinb_o, upd_valid_o, upd_addr_o, upd_count_o
   );

   modport slave (
      input  in_valid_i, in_addr_i, in_inc_i, ram_douta_i,
      output in_ready_o, ram_wea_o, ram_addra_o, ram_dina_o, ram_web_o, ram_addrb_o,
             ram_dinb_o, upd_valid_o, upd_addr_o, upd_count_o
   );
endinterface

// File: rtl/sketch_update_ctrl.sv
// Read-modify-write sketch counter update engine with zero-fill sweep and hazard forwarding.
// Optional macro SKETCH_SAT_EN: saturate counters at all-ones instead of wrapping.
module sketch_update_ctrl #(
   parameter int unsigned DW = 32,
   parameter int unsigned HW = 10,
   parameter int unsigned IW = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear_i,
   output logic                init_done_o,
   sketch_update_ctrl_if.slave bus
);
   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e        state_q, state_d;
   logic [HW-1:0] sweep_q, sweep_d;
   logic          s1_valid_q, s1_valid_d;
   logic [HW-1:0] s1_addr_q, s1_addr_d;
   logic [IW-1:0] s1_inc_q, s1_inc_d;
   logic          fwd_valid_q, fwd_valid_d;
   logic [HW-1:0] fwd_addr_q, fwd_addr_d;
   logic [DW-1:0] fwd_data_q, fwd_data_d;
   logic [HW-1:0] addra_q, addra_d;
   logic          accept;
   logic [DW-1:0] base;
   logic [DW-1:0] inc_ext;
   logic [DW-1:0] sum;
`ifdef SKETCH_SAT_EN
   logic [DW:0]   sum_ext;
`endif

   // The previous cycle's write is not yet visible in the registered read data.
   always_comb begin
      base = (fwd_valid_q && (fwd_addr_q == s1_addr_q)) ? fwd_data_q : bus.ram_douta_i;
      inc_ext = '0;
      inc_ext[IW-1:0] = s1_inc_q;
`ifdef SKETCH_SAT_EN
      sum_ext = {1'b0, base} + {1'b0, inc_ext};
      sum = sum_ext[DW] ? '1 : sum_ext[DW-1:0];
`else
      sum = base + inc_ext;
`endif
   end

   always_comb begin
      state_d     = state_q;
      sweep_d     = sweep_q;
      s1_valid_d  = 1'b0;
      s1_addr_d   = s1_addr_q;
      s1_inc_d    = s1_inc_q;
      fwd_valid_d = s1_valid_q;
      fwd_addr_d  = s1_addr_q;
      fwd_data_d  = sum;
      addra_d     = addra_q;
      accept      = 1'b0;
      unique case (state_q)
         StInit: begin
            sweep_d = sweep_q + HW'(1);
            if (sweep_q == '1) state_d = StRun;
         end
         StRun: begin
            accept = bus.in_valid_i & ~clear_i;
            if (accept) begin
               s1_valid_d = 1'b1;
               s1_addr_d  = bus.in_addr_i;
               s1_inc_d   = bus.in_inc_i;
               addra_d    = bus.in_addr_i;
            end
            // No item is accepted with clear, so S1 is empty by the first sweep cycle.
            if (clear_i) begin
               state_d     = StInit;
               sweep_d     = '0;
               fwd_valid_d = 1'b0;
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_comb begin
      bus.in_ready_o  = 1'b0;
      bus.ram_wea_o   = 1'b0;
      bus.ram_dina_o  = '0;
      bus.ram_addra_o = addra_q;
      bus.ram_web_o   = 1'b0;
      bus.ram_addrb_o = '0;
      bus.ram_dinb_o  = '0;
      bus.upd_valid_o = 1'b0;
      bus.upd_addr_o  = '0;
      bus.upd_count_o = '0;
      init_done_o     = 1'b0;
      // Held quiet while reset is asserted so the sweep starts only once it is released.
      if (!rst) begin
         unique case (state_q)
            StInit: begin
               bus.ram_web_o   = 1'b1;
               bus.ram_addrb_o = sweep_q;
            end
            StRun: begin
               init_done_o     = 1'b1;
               bus.in_ready_o  = ~clear_i;
               bus.ram_addra_o = addra_d;
               if (s1_valid_q) begin
                  bus.ram_web_o   = 1'b1;
                  bus.ram_addrb_o = s1_addr_q;
                  bus.ram_dinb_o  = sum;
                  bus.upd_valid_o = 1'b1;
                  bus.upd_addr_o  = s1_addr_q;
                  bus.upd_count_o = sum;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StInit;
         sweep_q     <= '0;
         s1_valid_q  <= 1'b0;
         s1_addr_q   <= '0;
         s1_inc_q    <= '0;
         fwd_valid_q <= 1'b0;
         fwd_addr_q  <= '0;
         fwd_data_q  <= '0;
         addra_q     <= '0;
      end else begin
         state_q     <= state_d;
         sweep_q     <= sweep_d;
         s1_valid_q  <= s1_valid_d;
         s1_addr_q   <= s1_addr_d;
         s1_inc_q    <= s1_inc_d;
         fwd_valid_q <= fwd_valid_d;
         fwd_addr_q  <= fwd_addr_d;
         fwd_data_q  <= fwd_data_d;
         addra_q     <= addra_d;
      end
   end
endmodule

// File: tb/tb_sketch_update_ctrl.sv
// Bench for sketch_update_ctrl: RAM model, behavioural counter model and per-cycle compare.
module tb_sketch_update_ctrl;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear_i;
   logic        init_done;
   logic        bd_we;
   logic [9:0]  bd_addr;
   logic [31:0] bd_data;

   int checks = 0;
   int failures = 0;

   sketch_update_ctrl_if #(.DW(32), .HW(10), .IW(8)) bus ();

   sketch_update_ctrl #(.DW(32), .HW(10), .IW(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (clear_i),
      .init_done_o (init_done),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Two-port RAM: port A registered read (read-first), port B write, plus bench backdoor.
   logic [31:0] mem [DEPTH];
   always @(posedge clk) begin
      bus.ram_douta_i <= mem[bus.ram_addra_o];
      if (bus.ram_web_o) mem[bus.ram_addrb_o] <= bus.ram_dinb_o;
      if (bd_we) mem[bd_addr] <= bd_data;
   end

   function automatic void chk(string name, longint got, longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   function automatic logic [31:0] add_model(logic [31:0] b, logic [7:0] i);
      longint s;
      s = longint'(b) + longint'(i);
`ifdef SKETCH_SAT_EN
      if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`endif
      return s[31:0];
   endfunction

   typedef struct {
      logic [9:0]  a;
      logic [31:0] v;
   } item_t;

   logic [31:0] model_mem [DEPTH];
   item_t       pend [$];
   logic [31:0] obs [$];
   int          init_left = DEPTH;
   int          sweep_idx = 0;
   int          sweep_seen = 0;

   // Compare process: sampled on the falling edge, inputs change 1 time unit after the rise.
   always @(negedge clk) begin
      item_t e;
      logic  exp_ready;
      if (rst) begin
         chk("rst_web", bus.ram_web_o, 0);
         chk("rst_ready", bus.in_ready_o, 0);
         chk("rst_upd_valid", bus.upd_valid_o, 0);
         chk("rst_init_done", init_done, 0);
         chk("rst_addrb", bus.ram_addrb_o, 0);
         chk("rst_dinb", bus.ram_dinb_o, 0);
         chk("rst_addra", bus.ram_addra_o, 0);
         init_left = DEPTH;
         sweep_idx = 0;
         pend.delete();
         foreach (model_mem[k]) model_mem[k] = '0;
      end else begin
         if (bus.upd_valid_o) obs.push_back(bus.upd_count_o);
         if (bus.ram_web_o && !init_done) sweep_seen++;
         chk("wea", bus.ram_wea_o, 0);
         chk("dina", bus.ram_dina_o, 0);
         if (init_left > 0) begin
            chk("init_web", bus.ram_web_o, 1);
            chk("init_addrb", bus.ram_addrb_o, sweep_idx);
            chk("init_dinb", bus.ram_dinb_o, 0);
            chk("init_ready", bus.in_ready_o, 0);
            chk("init_done_lo", init_done, 0);
            chk("init_upd_valid", bus.upd_valid_o, 0);
            sweep_idx++;
            init_left--;
         end else begin
            exp_ready = !clear_i;
            chk("run_ready", bus.in_ready_o, exp_ready);
            chk("run_init_done", init_done, 1);
            if (pend.size() > 0) begin
               e = pend.pop_front();
               chk("commit_web", bus.ram_web_o, 1);
               chk("commit_addrb", bus.ram_addrb_o, e.a);
               chk("commit_dinb", bus.ram_dinb_o, e.v);
               chk("commit_upd_valid", bus.upd_valid_o, 1);
               chk("commit_upd_addr", bus.upd_addr_o, e.a);
               chk("commit_upd_count", bus.upd_count_o, e.v);
            end else begin
               chk("idle_web", bus.ram_web_o, 0);
               chk("idle_upd_valid", bus.upd_valid_o, 0);
            end
            if (exp_ready && bus.in_valid_i) begin
               chk("accept_addra", bus.ram_addra_o, bus.in_addr_i);
               model_mem[bus.in_addr_i] = add_model(model_mem[bus.in_addr_i], bus.in_inc_i);
               e.a = bus.in_addr_i;
               e.v = model_mem[bus.in_addr_i];
               pend.push_back(e);
            end
            if (clear_i) begin
               init_left = DEPTH;
               sweep_idx = 0;
               foreach (model_mem[k]) model_mem[k] = '0;
            end
         end
         if (bd_we) model_mem[bd_addr] = bd_data;
      end
   end

   task automatic step(input logic v, input logic [9:0] a, input logic [7:0] i, input logic c);
      bus.in_valid_i = v;
      bus.in_addr_i  = a;
      bus.in_inc_i   = i;
      clear_i        = c;
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      clear_i        = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 10'd0, 8'd0, 1'b0);
   endtask

   initial begin
      int base_idx;
      int sweep_base;
      rst = 1'b1;
      clear_i = 1'b0;
      bd_we = 1'b0;
      bd_addr = '0;
      bd_data = '0;
      bus.in_valid_i = 1'b0;
      bus.in_addr_i = '0;
      bus.in_inc_i = '0;
      // Garbage-fill the RAM so the zero-fill is observable.
      for (int k = 0; k < DEPTH; k++) begin
         bd_we = 1'b1;
         bd_addr = 10'(k);
         bd_data = $urandom;
         @(posedge clk);
         #1;
      end
      bd_we = 1'b0;
      rst = 1'b0;
      idle(1030);
      chk("lit_init_sweep_len", sweep_seen, 1024);

      base_idx = obs.size();
      step(1'b1, 10'd5, 8'd3, 1'b0);
      idle(2);
      chk("lit_single_n", obs.size() - base_idx, 1);
      chk("lit_single_val", obs[base_idx], 32'd3);

      base_idx = obs.size();
      for (int k = 1; k <= 4; k++) step(1'b1, 10'd7, 8'(k), 1'b0);
      idle(2);
      chk("lit_b2b_n", obs.size() - base_idx, 4);
      chk("lit_b2b_0", obs[base_idx], 32'd1);
      chk("lit_b2b_1", obs[base_idx + 1], 32'd3);
      chk("lit_b2b_2", obs[base_idx + 2], 32'd6);
      chk("lit_b2b_3", obs[base_idx + 3], 32'd10);
      chk("lit_ram7", mem[7], 32'd10);

      base_idx = obs.size();
      step(1'b1, 10'd9, 8'd1, 1'b0);
      step(1'b1, 10'd10, 8'd1, 1'b0);
      step(1'b1, 10'd9, 8'd1, 1'b0);
      idle(2);
      chk("lit_alt_0", obs[base_idx], 32'd1);
      chk("lit_alt_1", obs[base_idx + 1], 32'd1);
      chk("lit_alt_2", obs[base_idx + 2], 32'd2);

      bd_we = 1'b1;
      bd_addr = 10'd3;
      bd_data = 32'hFFFF_FFFE;
      idle(1);
      bd_we = 1'b0;
      idle(1);
      base_idx = obs.size();
      step(1'b1, 10'd3, 8'd5, 1'b0);
      idle(2);
`ifdef SKETCH_SAT_EN
      chk("lit_sat", obs[base_idx], 32'hFFFF_FFFF);
`else
      chk("lit_wrap", obs[base_idx], 32'h0000_0003);
`endif

      base_idx = obs.size();
      sweep_base = sweep_seen;
      step(1'b1, 10'd2, 8'd1, 1'b0);
      step(1'b0, 10'd0, 8'd0, 1'b1);
      idle(1030);
      chk("lit_clear_commit", obs[base_idx], 32'd1);
      chk("lit_clear_sweep_len", sweep_seen - sweep_base, 1024);
      chk("lit_clear_ram2", mem[2], 32'd0);
      base_idx = obs.size();
      step(1'b1, 10'd2, 8'd4, 1'b0);
      idle(2);
      chk("lit_after_clear", obs[base_idx], 32'd4);

      base_idx = obs.size();
      step(1'b1, 10'd20, 8'd9, 1'b0);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1030);
      chk("lit_rst_drop_n", obs.size() - base_idx, 0);
      chk("lit_rst_ram20", mem[20], 32'd0);

      for (int k = 0; k < 3000; k++) begin
         step(($urandom % 10) < 7, 10'($urandom % 16), 8'($urandom), ($urandom % 300) == 0);
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
